// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - FIR MAC core defaults, coefficient table, state encoding and output scaling
package fir_pkg;

  localparam int FIR_DATA_W = 16;
  localparam int FIR_COEF_W = 16;
  localparam int FIR_TAPS   = 8;
  localparam int FIR_IDX_W  = $clog2(FIR_TAPS);

  // Q1.15 default taps: h0 = 0.5, rest zero, i.e. half-gain pass-through
  localparam logic signed [15:0] FIR_COEFS [FIR_TAPS] = '{
    16'sh4000, 16'sh0000, 16'sh0000, 16'sh0000,
    16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  // Default tap k rescaled from the Q1.15 table to Q1.(coef_w-1); taps past the table are zero
  function automatic logic signed [63:0] fir_default_coef(input int k, input int coef_w);
    logic signed [63:0] v;
    if (k < FIR_TAPS) v = 64'(FIR_COEFS[FIR_IDX_W'(k)]);
    else              v = 64'sd0;
    if (coef_w >= 16) return v <<< (coef_w - 16);
    else              return v >>> (16 - coef_w);
  endfunction

  // Round half up from Q2.(coef_w+data_w-2) accumulator to Q1.(data_w-1), then clamp
  function automatic logic signed [63:0] fir_round_sat(input logic signed [63:0] acc,
                                                       input int coef_w, input int data_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (coef_w - 2))) >>> (coef_w - 1);
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (r > hi)      return hi;
    else if (r < lo) return lo;
    else             return r;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// rtl/fir_delay_line.sv - circular sample buffer with write pointer and tap-relative read
module fir_delay_line #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        i_we,
  input  logic signed [DATA_W-1:0]    i_wdata,
  input  logic                        i_adv,
  input  logic [$clog2(TAPS)-1:0]     i_k,
  output logic signed [DATA_W-1:0]    o_rdata
);

  localparam int PTR_W = $clog2(TAPS);

  logic signed [DATA_W-1:0] r_mem [TAPS];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         w_rd_idx;

  // TAPS is a power of two, so plain PTR_W-bit subtraction gives the modulo wrap
  assign w_rd_idx = r_wr_ptr - i_k;
  assign o_rdata  = r_mem[w_rd_idx];

  // Newest sample lands at wr_ptr; pointer moves on only once its MAC pass is done
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < TAPS; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (i_we)  r_mem[r_wr_ptr] <= i_wdata;
      if (i_adv) r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fir_mac_core.sv
// rtl/fir_mac_core.sv - time-multiplexed single-MAC FIR filter; COEF_LOAD_EN adds a coefficient write port
module fir_mac_core
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int COEF_W = FIR_COEF_W,
  parameter int TAPS   = FIR_TAPS,
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  out_data,
  input  logic                      out_ready
`ifdef COEF_LOAD_EN
  ,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data
`endif
);

  localparam int PTR_W = $clog2(TAPS);
  localparam int K_W   = PTR_W + 1;

  fir_state_e                      r_state;
  logic [K_W-1:0]                  r_k;
  logic signed [ACC_W-1:0]         r_acc;
  logic                            r_in_ready;
  logic                            r_out_valid;
  logic signed [DATA_W-1:0]        r_out_data;

  logic                            w_accept;
  logic                            w_mac_done;
  logic                            w_adv;
  logic signed [DATA_W-1:0]        w_x;
  logic signed [COEF_W-1:0]        w_h;
  logic signed [DATA_W+COEF_W-1:0] w_prod;
  logic signed [ACC_W-1:0]         w_prod_ext;
  logic signed [63:0]              w_round;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // r_in_ready is only ever high in IDLE; the state term keeps that explicit
  assign w_accept   = in_valid && r_in_ready && (r_state == ST_IDLE);
  // k reaching TAPS is the extra finalize cycle that scales the accumulator
  assign w_mac_done = r_k[PTR_W];
  assign w_adv      = (r_state == ST_MAC) && w_mac_done;

  fir_delay_line #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_delay_line (
    .CLK     (CLK),
    .RST     (RST),
    .i_we    (w_accept),
    .i_wdata (in_data),
    .i_adv   (w_adv),
    .i_k     (r_k[PTR_W-1:0]),
    .o_rdata (w_x)
  );

`ifdef COEF_LOAD_EN
  logic signed [COEF_W-1:0] r_coef [TAPS];

  // Coefficient RAM: writes land only in IDLE, so a pass in flight never sees a mixed set
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < TAPS; i++) r_coef[i] <= COEF_W'(fir_default_coef(i, COEF_W));
    end else if (coef_we && (r_state == ST_IDLE)) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  assign w_h = r_coef[r_k[PTR_W-1:0]];
`else
  logic signed [COEF_W-1:0] w_coef_rom [TAPS];

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef_rom
    assign w_coef_rom[gi] = COEF_W'(fir_default_coef(gi, COEF_W));
  end

  assign w_h = w_coef_rom[r_k[PTR_W-1:0]];
`endif

  // Full-precision product, sign-extended so TAPS worst-case terms cannot overflow
  assign w_prod     = w_x * w_h;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_round    = fir_round_sat(64'(r_acc), COEF_W, DATA_W);

  // Control FSM: IDLE accepts a sample, MAC runs TAPS products plus a finalize cycle, OUT holds the result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_acc      <= '0;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_MAC;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_MAC: begin
          if (!w_mac_done) begin
            r_acc <= r_acc + w_prod_ext;
            r_k   <= r_k + 1'b1;
          end else begin
            r_out_data  <= DATA_W'(w_round);
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_core.sv
// tb/tb_fir_mac_core.sv - directed self-checking bench for fir_mac_core
module tb_fir_mac_core;

  localparam int TAPS = 8;

  logic        CLK       = 1'b0;
  logic        RST       = 1'b1;
  logic        in_valid  = 1'b0;
  logic [15:0] in_data   = 16'h0000;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
`ifdef COEF_LOAD_EN
  logic        coef_we   = 1'b0;
  logic [2:0]  coef_addr = 3'd0;
  logic [15:0] coef_data = 16'h0000;
`endif

  int checks = 0;
  int errors = 0;

  fir_mac_core dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef COEF_LOAD_EN
    ,
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data)
`endif
  );

  always #31 CLK = ~CLK;

  initial begin
    #(62 * 60000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at accept edge+1 with in_valid dropped
  task automatic accept(input logic [15:0] x);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = x;
    while (in_ready !== 1'b1 && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    check("accept_timeout", 32'(n < 40), 32'd1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen
  task automatic wait_out(output logic [15:0] y, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    y = out_data;
  endtask

  task automatic run(input logic [15:0] x, input logic [15:0] exp, input bit chk, input string tag);
    logic [15:0] y;
    int lat;
    accept(x);
    wait_out(y, lat);
    if (chk) check(tag, 32'(y), 32'(exp));
    check({tag, "_lat"}, 32'(lat), 32'(TAPS + 1));
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

`ifdef COEF_LOAD_EN
  task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(posedge CLK); #1;
    coef_we   = 1'b0;
  endtask
`endif

  logic [15:0] rx [7];
  logic [15:0] ry [7];

  initial begin
    logic [15:0] y;
    int          lat;
    bit          seen;

    rx = '{16'h0001, 16'hFFFF, 16'h0003, 16'hFFFD, 16'h7FFF, 16'h8000, 16'h1235};
    ry = '{16'h0001, 16'h0000, 16'h0002, 16'hFFFF, 16'h4000, 16'hC000, 16'h091B};

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Impulse through default coefficients
    run(16'h4000, 16'h2000, 1'b1, "imp0");
    for (int i = 0; i < 7; i++) run(16'h0000, 16'h0000, 1'b1, "imp_tail");

    // Rounding (half up) and sign handling at 0.5 gain
    for (int i = 0; i < 7; i++) run(rx[i], ry[i], 1'b1, "round");

    // in_ready held low while the MAC pass runs
    accept(16'h0002);
    check("mac_in_ready", 32'(in_ready), 32'd0);
    wait_out(y, lat);
    check("mac_out", 32'(y), 32'h0001);
    @(posedge CLK); #1;

    // Backpressure: result held, in_valid pulses ignored
    out_ready = 1'b0;
    accept(16'h4000);
    wait_out(y, lat);
    check("bp_first", 32'(y), 32'h2000);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h7FFF;
      @(posedge CLK); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'h2000);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    check("bp_release", 32'(out_valid), 32'd0);
    run(16'h0000, 16'h0000, 1'b1, "bp_next");

    // Reset at k=3 discards the pass
    accept(16'h4000);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    RST = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("midrst_no_out", 32'(seen), 32'd0);
    run(16'h4000, 16'h2000, 1'b1, "midrst_imp0");
    run(16'h0000, 16'h0000, 1'b1, "midrst_imp1");

`ifdef COEF_LOAD_EN
    // Coefficient load in IDLE
    do_reset();
    write_coef(3'd1, 16'h7FFF);
    run(16'h4000, 16'h2000, 1'b1, "cl_imp0");
    run(16'h0000, 16'h4000, 1'b1, "cl_imp1");
    // Write during MAC is dropped
    accept(16'h0000);
    write_coef(3'd0, 16'h0000);
    wait_out(y, lat);
    check("cl_drop_out", 32'(y), 32'h0000);
    @(posedge CLK); #1;
    run(16'h4000, 16'h2000, 1'b1, "cl_drop_h0");
    // Write in the accept cycle applies to that sample: h0=0 leaves only prev*h1
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'h0000;
    accept(16'h4000);
    coef_we = 1'b0;
    wait_out(y, lat);
    check("cl_same_cycle", 32'(y), 32'h4000);
    @(posedge CLK); #1;

    // Saturation with all taps at max
    do_reset();
    for (int i = 0; i < 8; i++) write_coef(3'(i), 16'h7FFF);
    for (int i = 0; i < 7; i++) run(16'h7FFF, 16'h0000, 1'b0, "sat_pos_fill");
    run(16'h7FFF, 16'h7FFF, 1'b1, "sat_pos");
    for (int i = 0; i < 7; i++) run(16'h8000, 16'h0000, 1'b0, "sat_neg_fill");
    run(16'h8000, 16'h8000, 1'b1, "sat_neg");

    // Wrap: reset must clear saturated history; two half taps
    do_reset();
    write_coef(3'd1, 16'h4000);
    run(16'h1000, 16'h0800, 1'b1, "wrap0");
    for (int i = 1; i < 10; i++) run(16'h1000, 16'h1000, 1'b1, "wrap");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
